mem_responder: RTL and testbench

//  Slave end of the core memory-request interface (mem_address/mem_datasize/mem_read/mem_write/mem_done)

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Core memory-request bus between a requester (fetch/load-store) and mem_responder.
// The requester holds a request until it sees the one-cycle mem_done pulse.
interface mem_responder_if;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;

    modport master (
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done
    );

    modport slave (
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done
    );
endinterface

// File: rtl/mem_responder.sv
// Serves one core memory request at a time over a 32-bit Avalon-MM master port.
// Octa accesses become two big-endian tetra beats; sub-word accesses use byte lanes.
module mem_responder #(
    parameter int ADDR_W = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_responder_if.slave      bus,
    output logic [ADDR_W-3:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [31:0]         avm_readdata,
    input  logic                avm_readdatavalid
);

    typedef enum logic [1:0] {IDLE, CMD, RDATA, DONE} state_t;

    state_t              state, state_next;
    logic                beat, beat_next;
    logic                is_read;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [63:0]         wdata_q;
    logic [63:0]         readdata_q;
    logic                latch, capture, done;
    logic                last_beat;

    // Big-endian lane map: byte offset 0 lives in bits [31:24] / byteenable bit 3.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_be = 4'b1000 >> off;
            2'd1:    lane_be = off[1] ? 4'b0011 : 4'b1100;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic bt,
                                               input logic [63:0] wd);
        case (size)
            2'd0:    lane_wdata = {4{wd[7:0]}};
            2'd1:    lane_wdata = {2{wd[15:0]}};
            2'd2:    lane_wdata = wd[31:0];
            default: lane_wdata = bt ? wd[31:0] : wd[63:32];
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic [31:0] rd);
        lane_extract = rd;
        if (size == 2'd0) begin
            case (off)
                2'd0:    lane_extract = {24'b0, rd[31:24]};
                2'd1:    lane_extract = {24'b0, rd[23:16]};
                2'd2:    lane_extract = {24'b0, rd[15:8]};
                default: lane_extract = {24'b0, rd[7:0]};
            endcase
        end else if (size == 2'd1) begin
            lane_extract = off[1] ? {16'b0, rd[15:0]} : {16'b0, rd[31:16]};
        end
    endfunction

    assign last_beat        = (size_q != 2'd3) || beat;
    assign bus.mem_readdata = readdata_q;
    assign bus.mem_done     = done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat       <= 1'b0;
            is_read    <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (latch) begin
                addr_q  <= bus.mem_address[ADDR_W-1:0];
                size_q  <= bus.mem_datasize;
                wdata_q <= bus.mem_writedata;
                is_read <= bus.mem_read;
            end
            if (capture) begin
                if (size_q == 2'd3) begin
                    if (beat) readdata_q[31:0]  <= avm_readdata;
                    else      readdata_q[63:32] <= avm_readdata;
                end else begin
                    readdata_q <= {32'b0, lane_extract(size_q, addr_q[1:0], avm_readdata)};
                end
            end
        end
    end

    always_comb begin
        state_next     = state;
        beat_next      = beat;
        latch          = 1'b0;
        capture        = 1'b0;
        done           = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_byteenable = 4'b0000;
        avm_writedata  = 32'b0;
        case (state)
            IDLE: begin
                beat_next = 1'b0;
                if (bus.mem_read || bus.mem_write) begin
                    latch      = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                avm_read       = is_read;
                avm_write      = !is_read;
                avm_address    = (size_q == 2'd3) ? {addr_q[ADDR_W-1:3], beat} : addr_q[ADDR_W-1:2];
                avm_byteenable = lane_be(size_q, addr_q[1:0]);
                avm_writedata  = lane_wdata(size_q, beat, wdata_q);
                if (!avm_waitrequest) begin
                    if (is_read) begin
                        state_next = RDATA;
                    end else if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        beat_next = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (avm_readdatavalid) begin
                    capture = 1'b1;
                    if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        beat_next  = 1'b1;
                        state_next = CMD;
                    end
                end
            end
            default: begin
                // Requests are deliberately not sampled here so a held request cannot re-issue.
                done       = 1'b1;
                beat_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a small Avalon-MM slave model (stalls, 1-cycle read latency).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.ADDR_W(26)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    // Avalon slave model
    logic [31:0] mem [int unsigned];
    int          stall_cfg = 0;
    int          stall_cnt;
    int          stall_total = 0;
    int          unstable = 0;
    logic        drop_rdv = 1'b0;
    logic        stray_rdv = 1'b0;
    logic [31:0] stray_data = 32'h0;
    logic        model_rdv;
    logic [31:0] model_rd;
    logic        was_stalled;
    logic [61:0] snap;
    logic [61:0] cmd_now;
    logic [31:0] wtmp;
    logic [23:0] acc_addr[$];
    logic [3:0]  acc_be[$];
    logic [31:0] acc_wd[$];

    assign cmd_now           = {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata};
    assign avm_waitrequest   = (avm_read || avm_write) && (stall_cnt < stall_cfg);
    assign avm_readdatavalid = model_rdv | stray_rdv;
    assign avm_readdata      = stray_rdv ? stray_data : model_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt   <= 0;
            model_rdv   <= 1'b0;
            model_rd    <= 32'h0;
            was_stalled <= 1'b0;
        end else begin
            model_rdv   <= 1'b0;
            was_stalled <= 1'b0;
            if (avm_read || avm_write) begin
                if (was_stalled && cmd_now !== snap) unstable <= unstable + 1;
                if (avm_waitrequest) begin
                    stall_cnt   <= stall_cnt + 1;
                    stall_total <= stall_total + 1;
                    was_stalled <= 1'b1;
                    snap        <= cmd_now;
                end else begin
                    stall_cnt <= 0;
                    acc_addr.push_back(avm_address);
                    acc_be.push_back(avm_byteenable);
                    acc_wd.push_back(avm_writedata);
                    if (avm_write) begin
                        wtmp = mem.exists(int'(avm_address)) ? mem[int'(avm_address)] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (avm_byteenable[i]) wtmp[8*i +: 8] = avm_writedata[8*i +: 8];
                        mem[int'(avm_address)] = wtmp;
                    end else begin
                        model_rdv <= !drop_rdv;
                        model_rd  <= mem.exists(int'(avm_address)) ? mem[int'(avm_address)] : 32'h0;
                    end
                end
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input string tag, input logic [63:0] a, input logic [1:0] sz,
                           input logic rd, input logic [63:0] wd,
                           output int done_cyc, output int pulses);
        int c;
        @(negedge clk);
        bus.mem_address   = a;
        bus.mem_datasize  = sz;
        bus.mem_writedata = wd;
        bus.mem_read      = rd;
        bus.mem_write     = !rd;
        done_cyc = -1;
        pulses   = 0;
        c        = 0;
        while (done_cyc < 0 && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (bus.mem_done === 1'b1) begin
                done_cyc = c;
                pulses++;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        vectors++;
        assert (done_cyc >= 0) else begin
            miscompares++;
            $error("FAIL %s_timeout: observed no mem_done in %0d cycles expected completion", tag, c);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.mem_done === 1'b1) pulses++;
        end
    endtask

    int dc, np, base, st0, pulses;

    initial begin
        bus.mem_address   = 64'h0;
        bus.mem_datasize  = 2'd0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_writedata = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done",     {63'b0, bus.mem_done}, 64'h0);
        chk("rst_readdata", bus.mem_readdata,      64'h0);
        chk("rst_avm_rw",   {62'b0, avm_read, avm_write}, 64'h0);
        chk("rst_avm_addr", {40'b0, avm_address},  64'h0);
        chk("rst_be",       {60'b0, avm_byteenable}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Tetra read, upper address bits ignored, low bits rounded down
        mem[32'h400] = 32'hDEADBEEF;
        base = acc_addr.size();
        request("t1", 64'h8000_0000_0000_1002, 2'd2, 1'b1, 64'h0, dc, np);
        chk("t1_done_cycle", 64'(dc), 64'd3);
        chk("t1_pulses",     64'(np), 64'd1);
        chk("t1_readdata",   bus.mem_readdata, 64'h0000_0000_DEAD_BEEF);
        chk("t1_addr",       {40'b0, acc_addr[base]}, 64'h400);
        chk("t1_be",         {60'b0, acc_be[base]},   64'hF);

        // Byte and wyde reads
        mem[32'h400] = 32'h11223344;
        base = acc_addr.size();
        request("t2b", 64'h1003, 2'd0, 1'b1, 64'h0, dc, np);
        chk("t2_byte_data", bus.mem_readdata, 64'h44);
        chk("t2_byte_be",   {60'b0, acc_be[base]}, 64'h1);
        base = acc_addr.size();
        request("t2w", 64'h1000, 2'd1, 1'b1, 64'h0, dc, np);
        chk("t2_wyde_data", bus.mem_readdata, 64'h1122);
        chk("t2_wyde_be",   {60'b0, acc_be[base]}, 64'hC);

        // Octa read with 3 stall cycles per beat
        mem[32'h800] = 32'h01234567;
        mem[32'h801] = 32'h89ABCDEF;
        stall_cfg = 3;
        st0  = stall_total;
        base = acc_addr.size();
        request("t3", 64'h2000, 2'd3, 1'b1, 64'h0, dc, np);
        stall_cfg = 0;
        chk("t3_addr0",    {40'b0, acc_addr[base]},   64'h800);
        chk("t3_addr1",    {40'b0, acc_addr[base+1]}, 64'h801);
        chk("t3_stalls",   64'(stall_total - st0), 64'd6);
        chk("t3_stable",   64'(unstable), 64'd0);
        chk("t3_readdata", bus.mem_readdata, 64'h0123_4567_89AB_CDEF);
        chk("t3_done_cycle", 64'(dc), 64'd11);
        chk("t3_pulses",   64'(np), 64'd1);

        // Wyde write
        mem[32'hC01] = 32'h0;
        base = acc_addr.size();
        request("t4", 64'h3006, 2'd1, 1'b0, 64'hBEEF, dc, np);
        chk("t4_addr",     {40'b0, acc_addr[base]}, 64'hC01);
        chk("t4_be",       {60'b0, acc_be[base]},   64'h3);
        chk("t4_wd_low",   {48'b0, acc_wd[base][15:0]}, 64'hBEEF);
        chk("t4_done_cycle", 64'(dc), 64'd2);
        chk("t4_pulses",   64'(np), 64'd1);
        chk("t4_mem",      {32'b0, mem[32'hC01]}, 64'h0000_BEEF);
        chk("t4_rd_kept",  bus.mem_readdata, 64'h0123_4567_89AB_CDEF);

        // Octa write then readback
        base = acc_addr.size();
        request("t5", 64'h4000, 2'd3, 1'b0, 64'hCAFEBABE_12345678, dc, np);
        chk("t5_addr0", {40'b0, acc_addr[base]},   64'h1000);
        chk("t5_addr1", {40'b0, acc_addr[base+1]}, 64'h1001);
        chk("t5_wd0",   {32'b0, acc_wd[base]},     64'hCAFEBABE);
        chk("t5_wd1",   {32'b0, acc_wd[base+1]},   64'h12345678);
        chk("t5_be",    {56'b0, acc_be[base], acc_be[base+1]}, 64'hFF);
        chk("t5_done_cycle", 64'(dc), 64'd3);
        request("t5r", 64'h4000, 2'd3, 1'b1, 64'h0, dc, np);
        chk("t5_readback", bus.mem_readdata, 64'hCAFEBABE_12345678);

        // Reset while waiting for read data, then a stray readdatavalid
        drop_rdv = 1'b1;
        @(negedge clk);
        bus.mem_address  = 64'h1000;
        bus.mem_datasize = 2'd2;
        bus.mem_read     = 1'b1;
        @(posedge clk); #1;
        chk("t6_cmd_read", {63'b0, avm_read}, 64'h1);
        @(posedge clk); #1;
        chk("t6_rdata_wait", {63'b0, avm_read}, 64'h0);
        reset_n = 1'b0;
        bus.mem_read = 1'b0;
        #1;
        chk("t6_rst_readdata", bus.mem_readdata, 64'h0);
        chk("t6_rst_avm", {62'b0, avm_read, avm_write}, 64'h0);
        @(negedge clk);
        reset_n  = 1'b1;
        drop_rdv = 1'b0;
        @(negedge clk);
        stray_rdv  = 1'b1;
        stray_data = 32'hFFFF_FFFF;
        @(negedge clk);
        stray_rdv = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_done === 1'b1 || avm_read === 1'b1) pulses++;
        end
        chk("t6_stray_quiet",    64'(pulses), 64'd0);
        chk("t6_stray_readdata", bus.mem_readdata, 64'h0);
        request("t6r", 64'h1000, 2'd2, 1'b1, 64'h0, dc, np);
        chk("t6_after_data", bus.mem_readdata, 64'h0000_0000_1122_3344);
        chk("t6_after_done", 64'(dc), 64'd3);
        chk("t6_after_pulses", 64'(np), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
